serial_eq_compare_ctrl: RTL
===========================

Name: serial_eq_compare_ctrl

Overview:
- Sequences a single external 1-bit equality comparator (inputs i0/i1, output eq) to compare two WIDTH-bit words bit-serially, LSB first.
- Captures both operands on a start request and steps a bit index through them, feeding one bit pair per clock to the comparator.
- Samples the comparator result and reports an overall equal/not-equal verdict plus the index of the first mismatching bit, using a start/done handshake.
- Sits between a requesting FSM (switch/button logic on Elbert V2) and the shared comparator cell.

Parameters:
- WIDTH, 8: operand width in bits, 2 to 32.
- IDX_W, 3: bit-index width; requires 2**IDX_W >= WIDTH.
- EARLY_EXIT, 1: 1 = stop at the first mismatching bit; 0 = always walk all WIDTH bits and report the lowest mismatch.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A, captured when start is accepted.
- b  in  WIDTH  operand B, captured when start is accepted.
- cmp_i0  out  1  to the comparator i0; current bit of captured A.
- cmp_i1  out  1  to the comparator i1; current bit of captured B.
- cmp_eq  in  1  from the comparator eq; combinational function of cmp_i0/cmp_i1.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- eq  out  1  1 = all bits equal; held until the next accepted start.
- mismatch_idx  out  IDX_W  lowest mismatching bit index; 0 when eq=1; held like eq.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state = IDLE.
  - busy, done, eq, mismatch_idx, cmp_i0, cmp_i1, internal index, operand registers and mismatch flag all 0.
  - Reset mid-RUN aborts the comparison with no done pulse.
- IDLE:
  - busy=0.
  - start=1 at an edge: capture a/b into registers, idx=0, clear the mismatch flag, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - cmp_i0 = A_reg[idx] and cmp_i1 = B_reg[idx], driven combinationally from registers.
  - cmp_eq is sampled at each edge.
  - On cmp_eq=0 with the mismatch flag clear: record mismatch_idx_next = idx and set the flag.
  - With EARLY_EXIT=1, the first mismatch goes straight to DONE with eq=0.
  - When idx = WIDTH-1 is sampled, go to DONE. eq = 1 if no mismatch was flagged (including this bit), else eq = 0; mismatch_idx = 0 when eq = 1.
  - Otherwise idx increments and the state stays RUN.
  - idx never exceeds WIDTH-1; there is no wrap.
- DONE:
  - done=1 and busy=1 for exactly one cycle; then return to IDLE.
  - cmp_i0 and cmp_i1 are 0 outside RUN.
- Start handling:
  - start is ignored while busy=1; there is no queueing.
  - start held high continuously re-triggers in the first IDLE cycle after DONE, so back-to-back requests are spaced by one IDLE cycle.
  - a/b changes after acceptance have no effect.
- Latency, counted from the start-accept edge E0:
  - Equal operands, or EARLY_EXIT=0: done is high in the cycle following edge E(WIDTH).
  - EARLY_EXIT=1 with first mismatch at bit k: done is high in the cycle following edge E(k+1).
- eq and mismatch_idx update on the edge entering DONE and remain stable until the next accepted start updates them again on its DONE entry. They are not cleared on start.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, start=0 for 10 cycles -> busy=done=eq=0, mismatch_idx=0, cmp_i0=cmp_i1=0 throughout.
- Equal words, WIDTH=8: a=b=8'hA5, start for 1 cycle -> cmp_i0/cmp_i1 walk 1,0,1,0,0,1,0,1; done pulses 8 cycles after accept; eq=1, mismatch_idx=0.
- Early exit, EARLY_EXIT=1: a=8'h0F, b=8'h0B (bit 2 differs) -> done 3 cycles after accept; eq=0, mismatch_idx=2; busy=1 for 4 cycles total.
- Full walk, EARLY_EXIT=0: a=8'h81, b=8'h00 -> done 8 cycles after accept; eq=0, mismatch_idx=0 (lowest mismatch, not bit 7).
- Ignored start and late operand change: during RUN, pulse start and change a to 8'hFF -> no restart, result reflects the captured operands; start held high -> next accept one IDLE cycle after the done cycle.
- Reset mid-operation: assert rst_n=0 at RUN idx=4 -> next cycle state IDLE, no done pulse, eq=0; a new start then completes normally.

Source files
------------

// File: rtl/serial_eq_compare_ctrl.sv
// rtl/serial_eq_compare_ctrl.sv - bit-serial equality sequencer for a shared 1-bit comparator
module serial_eq_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_i0,
  output logic             cmp_i1,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDX_W-1:0] mismatch_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mm_flag_q, mm_flag_d;
  logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;

  // Per-bit view of the comparator result for the bit currently presented.
  logic             bit_mm;
  logic             first_mm;
  logic             any_mm;
  logic [IDX_W-1:0] lowest_idx;
  logic             finish_run;

  // State and datapath registers; reset aborts any walk in progress with no done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      mm_flag_q <= 1'b0;
      mm_idx_q  <= '0;
      eq_q      <= 1'b0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      mm_flag_q <= mm_flag_d;
      mm_idx_q  <= mm_idx_d;
      eq_q      <= eq_d;
      res_idx_q <= res_idx_d;
    end
  end

  // Mismatch bookkeeping for the bit pair the comparator is looking at this cycle.
  always_comb begin
    bit_mm     = ~cmp_eq;
    first_mm   = bit_mm & ~mm_flag_q;
    any_mm     = mm_flag_q | bit_mm;
    lowest_idx = mm_flag_q ? mm_idx_q : idx_q;
    finish_run = (idx_q == LAST_IDX) || ((EARLY_EXIT != 0) && first_mm);
  end

  // Next-state logic: capture on accept, walk LSB first, publish the verdict on DONE entry.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    mm_flag_d = mm_flag_q;
    mm_idx_d  = mm_idx_q;
    eq_d      = eq_q;
    res_idx_d = res_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = '0;
          mm_flag_d = 1'b0;
          mm_idx_d  = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (first_mm) begin
          mm_flag_d = 1'b1;
          mm_idx_d  = idx_q;
        end
        if (finish_run) begin
          // The verdict includes the bit being sampled on this edge.
          eq_d      = ~any_mm;
          res_idx_d = any_mm ? lowest_idx : '0;
          state_d   = S_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      S_DONE: begin
        // start is not looked at here, so a held start re-accepts one IDLE cycle later.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparator drive is forced low outside RUN so the shared cell sees a quiet bus.
  always_comb begin
    cmp_i0 = 1'b0;
    cmp_i1 = 1'b0;
    if (state_q == S_RUN) begin
      cmp_i0 = a_q[idx_q];
      cmp_i1 = b_q[idx_q];
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign eq           = eq_q;
  assign mismatch_idx = res_idx_q;

endmodule
